// File: rtl/alu_tile_host_driver.sv
// alu_tile_host_driver: queues host commands in a small FIFO, issues them one at
// a time to an ALU tile, and returns each tile result through a valid/ready port.
// Optional feature macro: ALU_HOST_TIMEOUT_EN adds a WAIT timeout that answers
// with rsp_data=0 and rsp_timeout=1 when the tile never replies.
module alu_tile_host_driver #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_a,
    input  logic [63:0] cmd_b,
    input  logic [15:0] cmd_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_timeout,
    output logic [63:0] host_in_a,
    output logic [63:0] host_in_b,
    output logic [15:0] host_in_ctrl,
    output logic        host_in_valid,
    input  logic [63:0] host_out_a,
    input  logic        host_out_valid,
    output logic        busy,
    output logic [7:0]  stray_cnt
);

    localparam int unsigned PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam bit CFG_OK = (FIFO_DEPTH >= 2) &&
                            ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                            (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535);

    // Reject illegal parameter sets at elaboration time.
    if (!CFG_OK) begin : g_cfg_err
        $error("alu_tile_host_driver: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [63:0]   r_fifo_a    [FIFO_DEPTH];
    logic [63:0]   r_fifo_b    [FIFO_DEPTH];
    logic [15:0]   r_fifo_ctrl [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_cmd_ready;
    logic          r_busy;
    logic          r_rsp_valid;
    logic [63:0]   r_rsp_data;
    logic [63:0]   r_host_a;
    logic [63:0]   r_host_b;
    logic [15:0]   r_host_ctrl;
    logic          r_host_valid;
    logic [7:0]    r_stray_cnt;

    logic          w_push;
    logic          w_pop;
    logic          w_resp_done;
    logic          w_idle_nxt;
    logic [CW-1:0] w_count_nxt;

    // Handshake decode and next-cycle occupancy / FSM-idle prediction.
    assign w_push      = cmd_valid && r_cmd_ready;
    assign w_pop       = (r_state == IDLE) && (r_count != '0);
    assign w_resp_done = (r_state == RESP) && rsp_ready;
    assign w_idle_nxt  = ((r_state == IDLE) && !w_pop) || w_resp_done;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // FIFO payload storage; entries need no reset because pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr]    <= cmd_a;
            r_fifo_b[r_wr_ptr]    <= cmd_b;
            r_fifo_ctrl[r_wr_ptr] <= cmd_ctrl;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
        end
    end

    // Registered cmd_ready and busy derived from next-cycle state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cmd_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
            r_busy      <= !w_idle_nxt || (w_count_nxt != '0);
        end
    end

`ifdef ALU_HOST_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_rsp_timeout;
    logic        w_to_hit;

    assign w_to_hit    = ((17'(r_to_cnt) + 17'd1) == 17'(TIMEOUT_CYCLES));
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Control FSM: pop, issue a single-cycle tile request, wait, hold response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_host_valid <= 1'b0;
            r_host_a     <= '0;
            r_host_b     <= '0;
            r_host_ctrl  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
`ifdef ALU_HOST_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            r_host_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_host_a     <= r_fifo_a[r_rd_ptr];
                        r_host_b     <= r_fifo_b[r_rd_ptr];
                        r_host_ctrl  <= r_fifo_ctrl[r_rd_ptr];
                        r_host_valid <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef ALU_HOST_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A tile result takes priority over a coincident timeout.
                    if (host_out_valid) begin
                        r_rsp_data  <= host_out_a;
                        r_rsp_valid <= 1'b1;
`ifdef ALU_HOST_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        r_state     <= RESP;
                    end
`ifdef ALU_HOST_TIMEOUT_EN
                    else if (w_to_hit) begin
                        r_rsp_data    <= '0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating count of tile results that arrive when nothing is awaited.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stray_cnt <= '0;
        end else if (host_out_valid && (r_state != WAIT) && (r_stray_cnt != 8'hFF)) begin
            r_stray_cnt <= r_stray_cnt + 8'd1;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign host_in_a     = r_host_a;
    assign host_in_b     = r_host_b;
    assign host_in_ctrl  = r_host_ctrl;
    assign host_in_valid = r_host_valid;
    assign stray_cnt     = r_stray_cnt;

endmodule

// File: tb/tb_alu_tile_host_driver.sv
// Scoreboard bench for alu_tile_host_driver: a tile model answers issued
// requests with a+b after a delay; issue order and responses are checked
// against queues filled when stimulus is accepted.
module tb_alu_tile_host_driver;

    localparam int unsigned TO = 8;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [15:0] ctrl;
    } cmd_t;

    typedef struct packed {
        logic        to;
        logic [63:0] d;
        logic [31:0] due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_a, cmd_b;
    logic [15:0] cmd_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_timeout;
    logic [63:0] host_in_a, host_in_b;
    logic [15:0] host_in_ctrl;
    logic        host_in_valid;
    logic [63:0] host_out_a;
    logic        host_out_valid;
    logic        busy;
    logic [7:0]  stray_cnt;

    logic        tile_vld = 1'b0;
    logic [63:0] tile_a = '0;
    logic        man_vld = 1'b0;
    logic [63:0] man_a = '0;

    assign host_out_valid = tile_vld | man_vld;
    assign host_out_a     = man_vld ? man_a : tile_a;

    always #5 clk = ~clk;

    alu_tile_host_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctrl(cmd_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .host_in_a(host_in_a), .host_in_b(host_in_b),
        .host_in_ctrl(host_in_ctrl), .host_in_valid(host_in_valid),
        .host_out_a(host_out_a), .host_out_valid(host_out_valid),
        .busy(busy), .stray_cnt(stray_cnt)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    cmd_t exp_issue[$];
    rsp_t exp_rsp[$];
    int   n_iss = 0;
    int   n_acc = 0;
    int   last_issue_cyc = 0;
    int   push_cyc = 0;
    logic [63:0] last_rsp = '0;

    bit tile_en = 1'b1;
    bit to_expect = 1'b0;
    int tile_fixed = 0;
    bit tile_pend = 1'b0;
    int tile_cnt = 0;
    logic [63:0] tile_res = '0;
    int rdy_mode = 2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Tile model: answers each request with a+b after a fixed or random delay.
    initial forever begin
        @(negedge clk);
        tile_vld = 1'b0;
        if (!rst_n) begin
            tile_pend = 1'b0;
        end else begin
            if (tile_pend) begin
                tile_cnt--;
                if (tile_cnt == 0) begin
                    tile_vld  = 1'b1;
                    tile_a    = tile_res;
                    tile_pend = 1'b0;
                    exp_rsp.push_back('{to: 1'b0, d: tile_res, due: 32'(cyc + 1)});
                end
            end
            if (host_in_valid) begin
                if (tile_en) begin
                    tile_pend = 1'b1;
                    tile_res  = host_in_a + host_in_b;
                    tile_cnt  = (tile_fixed != 0) ? tile_fixed : int'($urandom_range(1, 6));
                end else if (to_expect) begin
                    // Issue at cycle I, TO waiting cycles, response visible at I+TO+1.
                    exp_rsp.push_back('{to: 1'b1, d: 64'd0, due: 32'(cyc + TO + 1)});
                end
            end
        end
    end

    // Host response-ready generator.
    initial forever begin
        @(posedge clk);
        #1;
        rsp_ready = (rdy_mode == 2) ? 1'b1 :
                    (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Issue monitor: order, payload, single-cycle pulse, one op outstanding.
    initial begin : issue_mon
        logic prev_iv;
        cmd_t e;
        prev_iv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_iv = 1'b0;
                exp_issue.delete();
                n_iss = n_acc;
            end else begin
                if (host_in_valid) begin
                    chk("issue_single_cycle", 65'(prev_iv), 65'd0);
                    chk("one_outstanding", 65'(n_iss - n_acc), 65'd0);
                    n_iss++;
                    last_issue_cyc = cyc;
                    if (exp_issue.size() == 0) begin
                        fail("issue_unexpected");
                    end else begin
                        e = exp_issue.pop_front();
                        chk("issue_a", 65'(host_in_a), 65'(e.a));
                        chk("issue_b", 65'(host_in_b), 65'(e.b));
                        chk("issue_ctrl", 65'(host_in_ctrl), 65'(e.ctrl));
                    end
                end
                prev_iv = host_in_valid;
            end
        end
    end

    // Response monitor: data, timeout flag, latency, stability under backpressure.
    initial begin : rsp_mon
        bit have;
        bit prev_acc;
        logic [64:0] cur;
        rsp_t e;
        have = 1'b0;
        prev_acc = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 1'b0;
                prev_acc = 1'b0;
                exp_rsp.delete();
            end else begin
                if (prev_acc) chk("rsp_low_after_accept", 65'(rsp_valid), 65'd0);
                if (rsp_valid) begin
                    if (!have) begin
                        if (exp_rsp.size() == 0) begin
                            fail("rsp_unexpected");
                        end else begin
                            e = exp_rsp.pop_front();
                            chk("rsp_data", 65'(rsp_data), 65'(e.d));
                            chk("rsp_timeout", 65'(rsp_timeout), 65'(e.to));
                            chk("rsp_latency", 65'(cyc), 65'(e.due));
                        end
                        cur = {rsp_timeout, rsp_data};
                        last_rsp = rsp_data;
                        have = 1'b1;
                    end else begin
                        chk("rsp_stable", {rsp_timeout, rsp_data}, cur);
                    end
                    if (rsp_ready) begin
                        have = 1'b0;
                        n_acc++;
                    end
                end
                prev_acc = rsp_valid && rsp_ready;
            end
        end
    end

    // Present a command and hold it until accepted; records the push cycle.
    task automatic push_cmd(input logic [63:0] a, input logic [63:0] b, input logic [15:0] c);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_ctrl = c;
        forever begin
            @(negedge clk);
            if (cmd_ready) begin
                exp_issue.push_back('{a: a, b: b, ctrl: c});
                push_cyc = cyc;
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
            t++;
            if (t > 300) begin
                fail("push_timeout");
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Wait until the DUT and all model queues are drained.
    task automatic wait_idle();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (!busy && !rsp_valid && !tile_pend && exp_issue.size() == 0 && exp_rsp.size() == 0) break;
            t++;
            if (t > 1000) begin
                fail("drain_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : main
        int base;
        int stray_model;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_ctrl = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 65'(cmd_ready), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        chk("rst_rsp_valid", 65'(rsp_valid), 65'd0);
        chk("rst_host_in_valid", 65'(host_in_valid), 65'd0);
        chk("rst_stray", 65'(stray_cnt), 65'd0);
        chk("rst_rsp_data", 65'(rsp_data), 65'd0);
        chk("rst_host_in_a", 65'(host_in_a), 65'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", 65'(cmd_ready), 65'd1);
        @(posedge clk);
        #1;

        // Single op: issue two cycles after push, tile returns 12 three cycles later.
        tile_fixed = 3;
        rdy_mode = 2;
        push_cmd(64'd5, 64'd7, 16'h0001);
        wait_idle();
        chk("issue_latency", 65'(last_issue_cyc), 65'(push_cyc + 2));
        chk("single_op_data", 65'(last_rsp), 65'd12);

        // Full FIFO and backpressure.
        tile_fixed = 0;
        rdy_mode = 0;
        base = n_iss;
        for (int i = 0; i < 5; i++) push_cmd(64'(100 + i), 64'(i), 16'(i + 16'h10));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full_cmd_ready", 65'(cmd_ready), 65'd0);
        chk("full_busy", 65'(busy), 65'd1);
        chk("full_one_issued", 65'(n_iss - base), 65'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_a = 64'd105;
        cmd_b = 64'd5;
        cmd_ctrl = 16'h15;
        repeat (20) begin
            @(negedge clk);
            chk("held_cmd_ready", 65'(cmd_ready), 65'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_no_more_issue", 65'(n_iss - base), 65'd1);
        chk("bp_rsp_valid", 65'(rsp_valid), 65'd1);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        push_cmd(64'd105, 64'd5, 16'h15);
        wait_idle();
        chk("full_all_issued", 65'(n_iss - base), 65'd6);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            push_cmd({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        chk("no_stray_in_traffic", 65'(stray_cnt), 65'd0);

`ifdef ALU_HOST_TIMEOUT_EN
        // Timeout with no tile reply, then reply on the last waiting cycle.
        tile_en = 1'b0;
        to_expect = 1'b1;
        push_cmd(64'd1, 64'd2, 16'h3);
        wait_idle();
        tile_en = 1'b1;
        to_expect = 1'b0;
        tile_fixed = TO;
        push_cmd(64'd40, 64'd2, 16'h4);
        wait_idle();
        chk("edge_result_wins", 65'(last_rsp), 65'd42);
        tile_fixed = 0;
`endif

        // Stray pulses while idle saturate at 255.
        stray_model = 0;
        for (int i = 0; i < 300; i++) begin
            man_vld = 1'b1;
            man_a = {$urandom, $urandom};
            @(posedge clk);
            #1;
            man_vld = 1'b0;
            if (stray_model < 255) stray_model++;
            if (i == 99) begin
                @(negedge clk);
                chk("stray_100", 65'(stray_cnt), 65'(stray_model));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("stray_sat", 65'(stray_cnt), 65'(stray_model));
        chk("stray_no_rsp", 65'(rsp_valid), 65'd0);
        chk("stray_not_busy", 65'(busy), 65'd0);
        @(posedge clk);
        #1;

        // Reset in WAIT with three commands queued.
        tile_en = 1'b0;
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) push_cmd(64'(200 + i), 64'd1, 16'(i));
        @(negedge clk);
        chk("pre_reset_busy", 65'(busy), 65'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_cmd_ready", 65'(cmd_ready), 65'd0);
        chk("mid_rst_busy", 65'(busy), 65'd0);
        chk("mid_rst_stray", 65'(stray_cnt), 65'd0);
        chk("mid_rst_host_in_valid", 65'(host_in_valid), 65'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_cmd_ready", 65'(cmd_ready), 65'd1);
        base = n_iss;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", 65'(busy), 65'd0);
        chk("post_rst_no_issue", 65'(n_iss - base), 65'd0);
        @(posedge clk);
        #1;
        man_vld = 1'b1;
        man_a = 64'hDEAD;
        @(posedge clk);
        #1;
        man_vld = 1'b0;
        @(negedge clk);
        chk("late_result_stray", 65'(stray_cnt), 65'd1);
        chk("late_result_no_rsp", 65'(rsp_valid), 65'd0);
        @(posedge clk);
        #1;
        tile_en = 1'b1;
        push_cmd(64'd30, 64'd3, 16'h7);
        wait_idle();
        chk("post_rst_op", 65'(last_rsp), 65'd33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
